// File: rtl/vc_injection_arbiter.sv
// Injection-side packet scheduler: shares one router local port between VC flit
// sources, granting whole packets by head priority with round-robin tie-break.

module vc_inj_lane (
  input  logic       i_valid,
  input  logic [3:0] i_hdr,
  output logic       o_head,
  output logic       o_tail,
  output logic [1:0] o_pri,
  output logic       o_bad_idle,
  output logic       o_bad_lock
);
  logic [1:0] w_type;
  assign w_type     = i_hdr[3:2];
  assign o_pri      = i_hdr[1:0];
  assign o_head     = i_valid && (w_type == 2'b01);
  assign o_tail     = i_valid && (w_type == 2'b11);
  assign o_bad_idle = i_valid && (w_type != 2'b01);
  // a locked owner may only send body or tail
  assign o_bad_lock = i_valid && ((w_type == 2'b01) || (w_type == 2'b10));
endmodule

module vc_injection_arbiter #(
  parameter int VC         = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [VC*DATA_WIDTH-1:0] data_in_vec,
  input  logic [VC-1:0]            valid_in_vec,
  output logic [VC-1:0]            ready_in_vec,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     valid_out,
  output logic [$clog2(VC)-1:0]    vc_out,
  input  logic                     ready_out,
  output logic                     protocol_err
);
  localparam int VCW = $clog2(VC);

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [VCW-1:0]        r_owner, r_rr_ptr, r_vc;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid, r_err;

  logic [VC-1:0]         w_head, w_tail, w_bad_idle, w_bad_lock, w_ready;
  logic [VC-1:0][1:0]    w_pri;
  logic                  w_accept, w_found, w_err, w_xfer;
  logic [VCW-1:0]        w_win, w_src, w_sel;
  logic [VCW:0]          w_sum;
  logic [1:0]            w_best;
  logic [DATA_WIDTH-1:0] w_flit;

  for (genvar v = 0; v < VC; v++) begin : g_lane
    vc_inj_lane u_lane (
      .i_valid    (valid_in_vec[v]),
      .i_hdr      (data_in_vec[v*DATA_WIDTH+28 +: 4]),
      .o_head     (w_head[v]),
      .o_tail     (w_tail[v]),
      .o_pri      (w_pri[v]),
      .o_bad_idle (w_bad_idle[v]),
      .o_bad_lock (w_bad_lock[v])
    );
  end

  assign w_accept = !r_valid || ready_out;

  // Scan upward from rr_ptr; only a strictly higher priority displaces the
  // current pick, so equal priorities resolve to the first VC in scan order.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_best  = '0;
    w_sum   = '0;
    w_sel   = '0;
    for (int k = 0; k < VC; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (VCW+1)'(k);
      if (w_sum >= (VCW+1)'(VC)) w_sum = w_sum - (VCW+1)'(VC);
      w_sel = w_sum[VCW-1:0];
      if (w_head[w_sel] && (!w_found || (w_pri[w_sel] > w_best))) begin
        w_found = 1'b1;
        w_win   = w_sel;
        w_best  = w_pri[w_sel];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_err = |w_bad_idle;
        if (w_found && w_accept) begin
          w_ready[w_win] = 1'b1;
          w_state_nxt    = S_LOCKED;
        end
      end
      S_LOCKED: begin
        w_err = w_bad_lock[r_owner];
        if (w_accept && !w_bad_lock[r_owner]) begin
          w_ready[r_owner] = 1'b1;
          if (w_tail[r_owner]) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!rst) begin
      w_ready     = '0;
      w_err       = 1'b0;
      w_state_nxt = S_IDLE;
    end
  end

  assign w_src  = (r_state == S_IDLE) ? w_win : r_owner;
  assign w_xfer = |(w_ready & valid_in_vec);

  always_comb begin
    w_flit = '0;
    for (int v = 0; v < VC; v++)
      if (w_src == VCW'(v)) w_flit = data_in_vec[v*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_vc     <= '0;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_err) r_err <= 1'b1;
      if (w_xfer) begin
        r_data  <= w_flit;
        r_valid <= 1'b1;
        r_vc    <= w_src;
      end else if (ready_out) begin
        r_valid <= 1'b0;
      end
      if (w_xfer && (r_state == S_IDLE)) begin
        r_owner  <= w_win;
        r_rr_ptr <= (w_win == VCW'(VC-1)) ? '0 : w_win + 1'b1;
      end
    end
  end

  assign ready_in_vec = w_ready;
  assign data_out     = r_data;
  assign valid_out    = r_valid;
  assign vc_out       = r_vc;
  assign protocol_err = r_err;
endmodule

// File: tb/tb_vc_injection_arbiter.sv
// Randomised bench for vc_injection_arbiter against a packet-level reference model,
// plus directed scenarios with literal expectations.

module tb_vc_injection_arbiter;
  localparam int VC  = 4;
  localparam int DW  = 32;
  localparam int VCW = $clog2(VC);

  logic              clk = 1'b0;
  logic              rst;
  logic [VC*DW-1:0]  data_in_vec;
  logic [VC-1:0]     valid_in_vec, ready_in_vec;
  logic [DW-1:0]     data_out;
  logic              valid_out, ready_out, protocol_err;
  logic [VCW-1:0]    vc_out;
  logic [DW-1:0]     din [VC];

  always #5 clk = ~clk;

  for (genvar g = 0; g < VC; g++) begin : g_pk
    assign data_in_vec[g*DW +: DW] = din[g];
  end

  vc_injection_arbiter #(.VC(VC), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .data_in_vec(data_in_vec), .valid_in_vec(valid_in_vec),
    .ready_in_vec(ready_in_vec), .data_out(data_out), .valid_out(valid_out),
    .vc_out(vc_out), .ready_out(ready_out), .protocol_err(protocol_err)
  );

  int n_tot = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] q [VC][$];
  int en_pct [VC];
  typedef struct { logic [DW-1:0] d; int vc; int c; } ent_t;
  ent_t olog [$];

  // reference model: packet-level view of the scheduler
  bit m_locked = 0, m_vout = 0, m_err = 0;
  int m_owner = 0, m_rr = 0, m_vc = 0;
  logic [DW-1:0] m_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ftype(int v); return din[v][31:30]; endfunction
  function automatic logic [1:0] fpri(int v);  return din[v][29:28]; endfunction

  function automatic int pick();
    int best = -1;
    for (int v = 0; v < VC; v++)
      if (valid_in_vec[v] && ftype(v) == 2'b01) begin
        if (best < 0) best = v;
        else if (fpri(v) > fpri(best)) best = v;
        else if (fpri(v) == fpri(best) &&
                 ((v - m_rr + VC) % VC) < ((best - m_rr + VC) % VC)) best = v;
      end
    return best;
  endfunction

  function automatic bit owner_bad();
    return valid_in_vec[m_owner] && (ftype(m_owner) == 2'b01 || ftype(m_owner) == 2'b10);
  endfunction

  function automatic logic [VC-1:0] exp_ready();
    logic [VC-1:0] r = '0;
    int w;
    if (rst && (!m_vout || ready_out)) begin
      if (m_locked) begin
        if (!owner_bad()) r[m_owner] = 1'b1;
      end else begin
        w = pick();
        if (w >= 0) r[w] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic bit exp_err();
    if (!rst) return 1'b0;
    if (m_locked) return owner_bad();
    for (int v = 0; v < VC; v++)
      if (valid_in_vec[v] && ftype(v) != 2'b01) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model
    logic [VC-1:0] r;
    int s;
    if (!rst) begin
      m_locked <= 0; m_owner <= 0; m_rr <= 0; m_vout <= 0; m_err <= 0;
      m_data <= '0; m_vc <= 0;
    end else begin
      r = exp_ready();
      s = -1;
      for (int v = 0; v < VC; v++) if (r[v] && valid_in_vec[v]) s = v;
      if (exp_err()) m_err <= 1;
      if (s >= 0) begin
        m_data <= din[s];
        m_vc   <= s;
        m_vout <= 1;
        if (!m_locked) begin
          m_locked <= 1; m_owner <= s; m_rr <= (s + 1) % VC;
        end else if (ftype(s) == 2'b11) begin
          m_locked <= 0;
        end
      end else if (ready_out) begin
        m_vout <= 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    chk("ready_in_vec", ready_in_vec, exp_ready());
    chk("valid_out", valid_out, m_vout);
    chk("data_out", data_out, m_data);
    chk("vc_out", vc_out, m_vc);
    chk("protocol_err", protocol_err, m_err);
    if (valid_out && ready_out) olog.push_back('{data_out, int'(vc_out), cyc});
  end

  task automatic drive();
    for (int v = 0; v < VC; v++) begin
      valid_in_vec[v] = (q[v].size() > 0) && ($urandom_range(99) < en_pct[v]);
      din[v]          = (q[v].size() > 0) ? q[v][0] : '0;
    end
  endtask

  task automatic step();
    logic [VC-1:0] hs;
    @(negedge clk);
    hs = valid_in_vec & ready_in_vec;
    @(posedge clk);
    #1;
    for (int v = 0; v < VC; v++) if (hs[v] && q[v].size() > 0) void'(q[v].pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int v = 0; v < VC; v++) q[v].delete();
    drive();
    step();
    step();
    rst = 1'b1;
    olog.delete();
  endtask

  function automatic bit busy(logic [VC-1:0] m);
    for (int v = 0; v < VC; v++) if (m[v] && q[v].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_done(input logic [VC-1:0] m, input int extra);
    int g = 0;
    while (busy(m) && g < 300) begin step(); g++; end
    n_tot++;
    if (g >= 300) begin
      n_bad++;
      $display("FAIL timeout act=%0d cycles req<300", g);
    end
    repeat (extra) step();
  endtask

  function automatic int lvc(int i); return (i < olog.size()) ? olog[i].vc : -1; endfunction
  function automatic logic [DW-1:0] ld(int i); return (i < olog.size()) ? olog[i].d : '1; endfunction
  function automatic int lc(int i); return (i < olog.size()) ? olog[i].c : -1; endfunction

  function automatic logic [DW-1:0] fl(logic [1:0] t, logic [1:0] p, int pay);
    return {t, p, 28'(pay)};
  endfunction

  initial begin
    logic [DW-1:0] p1 [4];
    int seq [6];
    int nst, g, len;
    int pat [12];

    for (int v = 0; v < VC; v++) en_pct[v] = 100;
    rst = 1'b0;
    ready_out = 1'b1;
    q[0].push_back(32'h4000_0001);
    drive();
    step();
    step();
    chk("rst_ready", ready_in_vec, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_vc_out", vc_out, 0);
    chk("rst_err", protocol_err, 0);

    // single VC, 4-flit packet, then a follow-up packet proves return to IDLE
    do_reset();
    p1[0] = 32'h4000_0A01; p1[1] = 32'h0000_0A02; p1[2] = 32'h0000_0A03; p1[3] = 32'hC000_0A04;
    for (int i = 0; i < 4; i++) q[2].push_back(p1[i]);
    drive();
    run_done(4'b0100, 2);
    chk("t1_count", olog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_data", ld(i), p1[i]);
      chk("t1_vc", lvc(i), 2);
      chk("t1_b2b", lc(i) - lc(0), i);
    end
    q[0].push_back(32'h4000_0B01);
    q[0].push_back(32'hC000_0B02);
    drive();
    run_done(4'b0001, 2);
    chk("t1_next_count", olog.size(), 6);
    chk("t1_next_vc", lvc(4), 0);

    // round robin with equal priorities, no bubbles
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int v = 0; v < VC; v++) begin
        q[v].push_back(fl(2'b01, 2'b00, v*16 + p));
        q[v].push_back(fl(2'b11, 2'b00, v*16 + p));
      end
    drive();
    run_done(4'b1111, 2);
    chk("t2_count", olog.size(), 24);
    for (int i = 0; i < 24; i++) begin
      chk("t2_data", ld(i), fl((i % 2 == 1) ? 2'b11 : 2'b01, 2'b00, ((i/2) % VC)*16 + (i/2)/VC));
      chk("t2_vc", lvc(i), (i/2) % VC);
      chk("t2_b2b", lc(i) - lc(0), i);
    end

    // priority beats round robin
    do_reset();
    q[1].push_back(fl(2'b01, 2'b01, 1)); q[1].push_back(fl(2'b11, 2'b01, 1));
    q[3].push_back(fl(2'b01, 2'b11, 3)); q[3].push_back(fl(2'b11, 2'b11, 3));
    drive();
    run_done(4'b1010, 2);
    chk("t3_count", olog.size(), 4);
    chk("t3_first", lvc(0), 3);
    chk("t3_second", lvc(2), 1);

    // high-priority head waits for the locked packet's tail
    do_reset();
    q[1].push_back(fl(2'b01, 2'b00, 0)); q[1].push_back(fl(2'b00, 2'b00, 1));
    q[1].push_back(fl(2'b00, 2'b00, 2)); q[1].push_back(fl(2'b11, 2'b00, 3));
    drive();
    step();
    step();
    q[0].push_back(fl(2'b01, 2'b11, 9)); q[0].push_back(fl(2'b11, 2'b11, 9));
    drive();
    run_done(4'b0011, 2);
    seq = '{1, 1, 1, 1, 0, 0};
    chk("t3b_count", olog.size(), 6);
    for (int i = 0; i < 6; i++) chk("t3b_vc", lvc(i), seq[i]);

    // backpressure during a 5-flit packet
    do_reset();
    for (int i = 0; i < 5; i++)
      q[1].push_back(fl((i == 0) ? 2'b01 : (i == 4) ? 2'b11 : 2'b00, 2'b00, 'hC00 + i));
    drive();
    pat = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    nst = 0;
    for (int i = 0; i < 12; i++) begin
      ready_out = pat[i][0];
      #1;
      if (valid_out && !ready_out) begin
        chk("t4_stall_ready", ready_in_vec, 0);
        nst++;
      end
      step();
    end
    ready_out = 1'b1;
    step();
    chk("t4_stalls", nst, 2);
    chk("t4_count", olog.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("t4_data", ld(i), fl((i == 0) ? 2'b01 : (i == 4) ? 2'b11 : 2'b00, 2'b00, 'hC00 + i));
      chk("t4_vc", lvc(i), 1);
    end

    // body flit in IDLE flags an error; other VCs still proceed
    do_reset();
    q[0].push_back(32'h0000_0001);
    q[2].push_back(fl(2'b01, 2'b00, 5)); q[2].push_back(fl(2'b00, 2'b00, 6));
    q[2].push_back(fl(2'b11, 2'b00, 7));
    drive();
    run_done(4'b0100, 2);
    chk("t5_err", protocol_err, 1);
    chk("t5_count", olog.size(), 3);
    for (int i = 0; i < 3; i++) chk("t5_vc", lvc(i), 2);
    chk("t5_vc0_held", q[0].size(), 1);
    q[0].delete();
    drive();

    // reset mid-packet
    do_reset();
    q[1].push_back(fl(2'b01, 2'b00, 1)); q[1].push_back(fl(2'b00, 2'b00, 2));
    q[1].push_back(fl(2'b00, 2'b00, 3)); q[1].push_back(fl(2'b11, 2'b00, 4));
    drive();
    g = 0;
    while (q[1].size() > 2 && g < 50) begin step(); g++; end
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t6_valid_out", valid_out, 0);
    chk("t6_err", protocol_err, 0);
    for (int v = 0; v < VC; v++) q[v].delete();
    olog.delete();
    q[0].push_back(fl(2'b01, 2'b00, 'hA)); q[0].push_back(fl(2'b11, 2'b00, 'hA));
    q[3].push_back(fl(2'b01, 2'b00, 'hB)); q[3].push_back(fl(2'b11, 2'b00, 'hB));
    drive();
    run_done(4'b1001, 2);
    chk("t6_count", olog.size(), 4);
    chk("t6_first", lvc(0), 0);
    chk("t6_second", lvc(2), 3);

    // randomised traffic, stalls, reserved-type glitches and resets
    for (int v = 0; v < VC; v++) en_pct[v] = 70;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(399) != 0);
      if (!rst) for (int v = 0; v < VC; v++) q[v].delete();
      ready_out = ($urandom_range(3) != 0);
      for (int v = 0; v < VC; v++)
        if (q[v].size() == 0 && $urandom_range(2) == 0) begin
          len = 2 + int'($urandom_range(3));
          g   = int'($urandom_range(3));
          for (int i = 0; i < len; i++)
            q[v].push_back(fl((i == 0) ? 2'b01 : (i == len-1) ? 2'b11 : 2'b00, 2'(g),
                              int'($urandom_range(32'h0FFF_FFFF))));
        end
      drive();
      if ($urandom_range(24) == 0) begin
        g = int'($urandom_range(VC-1));
        if (valid_in_vec[g]) din[g][31:30] = 2'b10;
      end
      step();
    end

    rst = 1'b1;
    ready_out = 1'b1;
    for (int v = 0; v < VC; v++) q[v].delete();
    drive();
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/vc_injection_arbiter.md
# vc_injection_arbiter

Synthesizable injection-side scheduler that shares one router local input channel between `VC` per-VC flit sources. It grants whole packets (head through tail) to one VC at a time, resolves contention by head-flit priority with round-robin tie-break, and presents the winning flit through a one-entry registered output stage. It sits between per-VC traffic generators (or core network interfaces) and the router's local `data_in`/`valid_in`/`ready_in` port, and tags each output flit with its VC index.

## Interface
- `VC`, 4, number of virtual-channel sources (2..8).
- `DATA_WIDTH`, 32, flit width; type field is `[31:30]`, priority field `[29:28]`.
- `VCW`, `$clog2(VC)`, width of the VC tag (localparam, not overridable).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset (sampled on `clk` rising edge while low).
- `data_in_vec`  in  `VC*DATA_WIDTH`  flit of VC v at `[v*DATA_WIDTH +: DATA_WIDTH]`.
- `valid_in_vec`  in  `VC`  per-VC flit valid.
- `ready_in_vec`  out  `VC`  per-VC accept; at most one bit high.
- `data_out`  out  `DATA_WIDTH`  registered flit to router.
- `valid_out`  out  1  registered flit valid.
- `vc_out`  out  `VCW`  VC index of the flit on `data_out`.
- `ready_out`  in  1  router accept.
- `protocol_err`  out  1  sticky error flag.

## Operation
- Flit types: `01` head, `00` body, `11` tail, `10` reserved. A transfer occurs on a port when valid and ready are both high at a rising edge.
- The output stage can accept when `!valid_out || ready_out`.
- State machine has two states:
  - IDLE: every VC whose `valid_in_vec[v]` is high and whose flit type is `01` is eligible.
    - Winner: the highest `[29:28]` priority. Ties go to the first eligible VC at or after `rr_ptr`, scanning upward with wrap.
    - `ready_in_vec[winner]` equals the output-stage accept condition.
    - On head transfer: go to LOCKED with `owner = winner`, and set `rr_ptr = winner+1` (mod `VC`).
  - LOCKED: only `ready_in_vec[owner]` may be high, and it equals the output-stage accept condition.
    - Other VCs stall regardless of priority.
    - A tail transfer from `owner` returns the FSM to IDLE.
    - A body or tail transfer leaves `rr_ptr` unchanged.
- Output register: on any input transfer, load `data_out` with the flit, set `valid_out=1`, and set `vc_out` to the source VC.
  - Otherwise, if `ready_out` is high, clear `valid_out`. `data_out` and `vc_out` hold their last value.
- Protocol errors set `protocol_err`, which stays set until reset. No flit is accepted from the offending VC on that cycle. Error conditions:
  - In IDLE, a VC presents valid with type `00`, `11` or `10`. That VC is simply not eligible.
  - In LOCKED, `owner` presents type `01` or `10`.
- Reset (`rst` low at an edge) clears `valid_out`, `data_out`, `vc_out`, `rr_ptr`, `owner` and `protocol_err` to 0, and forces IDLE.
  - `ready_in_vec` is 0 while `rst` is low.
  - A packet interrupted by reset is abandoned. The source must restart from a head.

## Timing
- Latency: a flit transferred at edge t appears on `data_out`/`valid_out` immediately after edge t.
- Throughput: one flit per cycle while `ready_out` stays high.
- Back-to-back packets:
  - Tail accepted at edge t puts the FSM in IDLE after t.
  - The next head can be accepted at edge t+1, so there is no bubble.
- Backpressure: `ready_out` low with `valid_out` high drops all `ready_in_vec` in the same cycle (combinational). No flit is lost or duplicated.
- `ready_in_vec` depends combinationally on `valid_in_vec`, `data_in_vec[31:28]`, `valid_out`, `ready_out` and state. There is no combinational path from `data_in` to `data_out`.
- Simultaneous tail accept and a new head request in the same cycle: the head waits for the IDLE cycle. Arbitration uses the updated `rr_ptr`.

## Test plan
- Single VC, 4-flit packet:
  - Stimulus: VC2 sends `0x4xxxxxxx`, `0x0…`, `0x0…`, `0xCxxxxxxx` with `ready_out=1`.
  - Required: four consecutive `valid_out` cycles, `vc_out=2`, `data_out` in order, FSM back to IDLE.
- Round-robin fairness:
  - Stimulus: all 4 VCs continuously offer equal-priority 2-flit packets.
  - Required: grant order 0,1,2,3,0… and no bubbles.
- Priority:
  - Stimulus: VC1 head priority 1 and VC3 head priority 3 arrive together with `rr_ptr=0`.
  - Required: VC3 wins.
  - Stimulus: a priority-3 head arrives on VC0 mid-VC1-packet.
  - Required: VC0 waits until VC1's tail.
- Backpressure:
  - Stimulus: `ready_out` toggles 1,0,0,1 during a 5-flit packet.
  - Required: the output flit sequence is identical to the no-stall case, with no drop or duplication, and `ready_in_vec=0` in the stalled cycles.
- Protocol error:
  - Stimulus: VC0 body flit `0x0…` valid in IDLE.
  - Required: `protocol_err` goes to 1, VC0 is not granted, and other VCs proceed.
- Reset mid-packet:
  - Stimulus: `rst` low for 1 cycle after 2 of 4 flits.
  - Required: `valid_out=0`, IDLE, `protocol_err=0`, `rr_ptr=0`, and a fresh head is accepted afterwards.
